// File: rtl/mblock_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mblock_initiator_pkg
// Shared definitions for the memory-block initiator: selector encodings (also
// used by the memory block's RAM write-enable decode), the FSM state type and
// small helpers for sizing the phase counter and classifying requests.
// -----------------------------------------------------------------------------
package mblock_initiator_pkg;

    // Memory region selectors
    localparam logic [1:0] SEL_ROM   = 2'b00;
    localparam logic [1:0] SEL_RAM   = 2'b01;
    localparam logic [1:0] SEL_IO    = 2'b10;
    localparam logic [1:0] SEL_CONST = 2'b11;

    // Initiator bus phases
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Largest of three phase lengths, used to size the shared down-counter
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Only RAM is writable and the IO region is reserved for any access
    function automatic logic isIllegal(input logic isWrite, input logic [1:0] sel);
        logic bad;
        case (sel)
            SEL_RAM:             bad = 1'b0;
            SEL_IO:              bad = 1'b1;
            SEL_ROM, SEL_CONST:  bad = isWrite;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mblock_phase_counter.sv
// -----------------------------------------------------------------------------
// mblock_phase_counter
// Loadable down-counter that times the SETUP and HOLD phases. It saturates at
// zero rather than wrapping, so a phase that sits at zero stays there.
// Ports:
//   clk_i        - clock
//   reset_i      - synchronous active-high reset, clears the count
//   load_i       - load loadValue_i this cycle (takes priority over counting)
//   loadValue_i  - value to load
//   zero_o       - count is zero (combinational from the count register)
// -----------------------------------------------------------------------------
module mblock_phase_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadValue_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise decrement until zero and stop there
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mblock_initiator.sv
// -----------------------------------------------------------------------------
// mblock_initiator
// Bus initiator between the CPU datapath and the memory block. Accepts one
// read/write request at a time, drives the memory selector/address/data with a
// setup-strobe-hold sequence so the write strobe only rises while everything
// else is stable, and returns read data or an error on a response channel.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   req_valid/req_ready               - request handshake (ready only in IDLE)
//   req_write, req_selector,
//   req_address, req_wdata            - request fields
//   resp_valid/resp_ready             - response handshake
//   resp_rdata, resp_err              - read data (0 for writes/errors), error
//   mem_selector, mem_address, mem_in - memory-side selector/address/data
//   mem_is_write                      - memory write strobe
//   mem_out                           - memory read data
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mblock_initiator
    import mblock_initiator_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int READ_WAIT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_selector,
    input  logic [15:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  mem_selector,
    output logic [15:0] mem_address,
    output logic [31:0] mem_in,
    output logic        mem_is_write,
    input  logic [31:0] mem_out
);

    localparam int MAX_PHASE = maxOf3(SETUP_CYCLES, HOLD_CYCLES, READ_WAIT);
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);

    // The counter holds "cycles remaining after this one", so a phase of N
    // cycles loads N-1 and ends in the cycle where the counter reads zero.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);

    state_e      state_q, state_d;
    logic        reqReady_q, reqReady_d;
    logic        respValid_q, respValid_d;
    logic [31:0] respRdata_q, respRdata_d;
    logic        respErr_q, respErr_d;
    logic [1:0]  memSel_q, memSel_d;
    logic [15:0] memAddr_q, memAddr_d;
    logic [31:0] memIn_q, memIn_d;
    logic        memIsWrite_q, memIsWrite_d;
    logic        isWrite_q, isWrite_d;

    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadValue;
    logic             cntZero;

    mblock_phase_counter #(
        .WIDTH(CNT_W)
    ) u_phase_counter (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (cntLoad),
        .loadValue_i (cntLoadValue),
        .zero_o      (cntZero)
    );

    // Next-state and next-output logic. Every register holds by default; the
    // memory-side fields are only written at accept and when leaving RESP, so
    // they cannot move while the strobe is high.
    always_comb begin
        state_d      = state_q;
        reqReady_d   = reqReady_q;
        respValid_d  = respValid_q;
        respRdata_d  = respRdata_q;
        respErr_d    = respErr_q;
        memSel_d     = memSel_q;
        memAddr_d    = memAddr_q;
        memIn_d      = memIn_q;
        memIsWrite_d = memIsWrite_q;
        isWrite_d    = isWrite_q;
        cntLoad      = 1'b0;
        cntLoadValue = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && reqReady_q) begin
                    reqReady_d = 1'b0;
                    if (isIllegal(req_write, req_selector)) begin
                        // Rejected requests never touch the memory side
                        state_d     = ST_RESP;
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                        respRdata_d = '0;
                    end else begin
                        state_d      = ST_SETUP;
                        memSel_d     = req_selector;
                        memAddr_d    = req_address;
                        memIn_d      = req_write ? req_wdata : 32'h0;
                        isWrite_d    = req_write;
                        cntLoad      = 1'b1;
                        cntLoadValue = req_write ? SETUP_LOAD : READ_LOAD;
                    end
                end
            end

            ST_SETUP: begin
                if (cntZero) begin
                    if (isWrite_q) begin
                        state_d      = ST_STROBE;
                        memIsWrite_d = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        respValid_d = 1'b1;
                        respErr_d   = 1'b0;
                        respRdata_d = mem_out;
                    end
                end
            end

            ST_STROBE: begin
                state_d      = ST_HOLD;
                memIsWrite_d = 1'b0;
                cntLoad      = 1'b1;
                cntLoadValue = HOLD_LOAD;
            end

            ST_HOLD: begin
                if (cntZero) begin
                    state_d     = ST_RESP;
                    respValid_d = 1'b1;
                    respErr_d   = 1'b0;
                    respRdata_d = '0;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d     = ST_IDLE;
                    reqReady_d  = 1'b1;
                    respValid_d = 1'b0;
                    respRdata_d = '0;
                    respErr_d   = 1'b0;
                    memSel_d    = '0;
                    memAddr_d   = '0;
                    memIn_d     = '0;
                    isWrite_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            reqReady_q   <= 1'b1;
            respValid_q  <= 1'b0;
            respRdata_q  <= '0;
            respErr_q    <= 1'b0;
            memSel_q     <= '0;
            memAddr_q    <= '0;
            memIn_q      <= '0;
            memIsWrite_q <= 1'b0;
            isWrite_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            reqReady_q   <= reqReady_d;
            respValid_q  <= respValid_d;
            respRdata_q  <= respRdata_d;
            respErr_q    <= respErr_d;
            memSel_q     <= memSel_d;
            memAddr_q    <= memAddr_d;
            memIn_q      <= memIn_d;
            memIsWrite_q <= memIsWrite_d;
            isWrite_q    <= isWrite_d;
        end
    end

    assign req_ready    = reqReady_q;
    assign resp_valid   = respValid_q;
    assign resp_rdata   = respRdata_q;
    assign resp_err     = respErr_q;
    assign mem_selector = memSel_q;
    assign mem_address  = memAddr_q;
    assign mem_in       = memIn_q;
    assign mem_is_write = memIsWrite_q;

endmodule

// File: tb/tb_mblock_initiator.sv
// -----------------------------------------------------------------------------
// tb_mblock_initiator
// Scoreboard bench: applyStimulus pushes the hand-computed expected response
// and memory-side behaviour into a queue and drives the request; a negedge
// monitor follows each transfer and compares when the response is handed off.
// A second instance with SETUP_CYCLES = 3 is used for reset-during-strobe.
// -----------------------------------------------------------------------------
module tb_mblock_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_selector;
    logic [15:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  mem_selector;
    logic [15:0] mem_address;
    logic [31:0] mem_in, mem_out;
    logic        mem_is_write;

    logic        reset3;
    logic        req_valid3, req_ready3, req_write3;
    logic [1:0]  req_selector3;
    logic [15:0] req_address3;
    logic [31:0] req_wdata3;
    logic        resp_valid3, resp_ready3, resp_err3;
    logic [31:0] resp_rdata3;
    logic [1:0]  mem_selector3;
    logic [15:0] mem_address3;
    logic [31:0] mem_in3, mem_out3;
    logic        mem_is_write3;

    int errors = 0;
    int checks = 0;
    int cycleCount = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          strobe;
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [31:0] din;
        int          held;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] ram [256];

    mblock_initiator dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_selector(req_selector), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_selector(mem_selector), .mem_address(mem_address), .mem_in(mem_in),
        .mem_is_write(mem_is_write), .mem_out(mem_out)
    );

    mblock_initiator #(.SETUP_CYCLES(3), .HOLD_CYCLES(1), .READ_WAIT(1)) dut3 (
        .clk(clk), .reset(reset3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
        .req_selector(req_selector3), .req_address(req_address3), .req_wdata(req_wdata3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3),
        .mem_selector(mem_selector3), .mem_address(mem_address3), .mem_in(mem_in3),
        .mem_is_write(mem_is_write3), .mem_out(mem_out3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Memory block model: ROM and CONST return address-derived patterns, RAM
    // is written on the clock edge that ends a strobe cycle
    always_comb begin
        case (mem_selector)
            2'b00:   mem_out = {16'hA0A0, mem_address};
            2'b01:   mem_out = ram[mem_address[7:0]];
            2'b11:   mem_out = {16'hC057, mem_address};
            default: mem_out = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_is_write && mem_selector == 2'b01) ram[mem_address[7:0]] <= mem_in;
    end

    assign mem_out3 = {16'hA0A0, mem_address3};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: tracks the transfer at the head of the queue from accept to
    // response handoff, then confirms the initiator is idle one cycle later
    int   acceptCycle, strobeSeen, strobeRel, firstLat, held, txn = 0;
    logic inFlight = 1'b0, memBad, stableBad, postPending = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            inFlight    = 1'b0;
            postPending = 1'b0;
        end else begin
            if (postPending) begin
                postPending = 1'b0;
                checkOutput($sformatf("t%0d_idle_ready", txn), req_ready, 1);
                checkOutput($sformatf("t%0d_idle_resp_valid", txn), resp_valid, 0);
                checkOutput($sformatf("t%0d_idle_mem_addr", txn), mem_address, 0);
            end
            if (!inFlight && req_valid && req_ready) begin
                inFlight    = 1'b1;
                acceptCycle = cycleCount;
                strobeSeen  = 0;
                strobeRel   = 0;
                firstLat    = -1;
                held        = 0;
                memBad      = 1'b0;
                stableBad   = 1'b0;
            end else if (inFlight && expQ.size() > 0) begin
                if (mem_address !== expQ[0].addr || mem_selector !== expQ[0].sel || mem_in !== expQ[0].din)
                    memBad = 1'b1;
                if (mem_is_write) begin
                    strobeSeen++;
                    strobeRel = cycleCount - acceptCycle;
                end
                if (resp_valid) begin
                    if (held == 0) firstLat = cycleCount - acceptCycle;
                    held++;
                    if (resp_rdata !== expQ[0].rdata || resp_err !== expQ[0].err || req_ready !== 1'b0)
                        stableBad = 1'b1;
                    if (resp_ready) begin
                        txn++;
                        checkOutput($sformatf("t%0d_rdata", txn), resp_rdata, expQ[0].rdata);
                        checkOutput($sformatf("t%0d_err", txn), resp_err, expQ[0].err);
                        checkOutput($sformatf("t%0d_latency", txn), firstLat, expQ[0].lat);
                        checkOutput($sformatf("t%0d_resp_cycles", txn), held, expQ[0].held);
                        checkOutput($sformatf("t%0d_strobe_count", txn), strobeSeen, (expQ[0].strobe != 0) ? 1 : 0);
                        if (expQ[0].strobe != 0)
                            checkOutput($sformatf("t%0d_strobe_cycle", txn), strobeRel, expQ[0].strobe);
                        checkOutput($sformatf("t%0d_mem_stable", txn), memBad, 0);
                        checkOutput($sformatf("t%0d_resp_stable", txn), stableBad, 0);
                        void'(expQ.pop_front());
                        inFlight    = 1'b0;
                        postPending = 1'b1;
                    end
                end
            end else if (resp_valid) begin
                checkOutput("unexpected_resp_valid", resp_valid, 0);
            end
        end
    end

    // Issue one request on the main instance and wait until the monitor has
    // retired it; held > 1 applies that many response cycles of backpressure
    task automatic applyStimulus(input logic w, input logic [1:0] sel, input logic [15:0] addr,
                                 input logic [31:0] wd, input logic [31:0] expRdata, input logic expErr,
                                 input int expLat, input int expStrobe, input logic [1:0] expSel,
                                 input logic [15:0] expAddr, input logic [31:0] expDin, input int expHeld);
        exp_t e;
        int   n;
        e.rdata = expRdata; e.err = expErr; e.lat = expLat; e.strobe = expStrobe;
        e.sel = expSel; e.addr = expAddr; e.din = expDin; e.held = expHeld;
        expQ.push_back(e);
        resp_ready   = (expHeld > 1) ? 1'b0 : 1'b1;
        req_write    = w;
        req_selector = sel;
        req_address  = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (expHeld > 1) begin
            n = 0;
            while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
            repeat (expHeld - 1) begin @(posedge clk); #1; end
            resp_ready = 1'b1;
        end
        n = 0;
        while (expQ.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout actual=pending required=retired");
            expQ.delete();
        end
    endtask

    // Reset the SETUP_CYCLES=3 instance during its strobe cycle, then make
    // sure no response leaks out and the next write runs to completion
    task automatic resetDuringStrobe();
        int   acc, n, strobes;
        logic sawResp;
        resp_ready3   = 1'b1;
        req_write3    = 1'b1;
        req_selector3 = 2'b01;
        req_address3  = 16'h0007;
        req_wdata3    = 32'h1122_3344;
        req_valid3    = 1'b1;
        acc = cycleCount;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        n = 0;
        while (!mem_is_write3 && n < 20) begin @(posedge clk); #1; n++; end
        checkOutput("r3_strobe_cycle", cycleCount - acc, 4);
        reset3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("r3_strobe_cleared", mem_is_write3, 0);
        checkOutput("r3_ready_after_reset", req_ready3, 1);
        checkOutput("r3_resp_after_reset", resp_valid3, 0);
        @(posedge clk); #1;
        reset3  = 1'b0;
        sawResp = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (resp_valid3) sawResp = 1'b1; end
        checkOutput("r3_no_dropped_resp", sawResp, 0);

        req_address3 = 16'h0009;
        req_wdata3   = 32'hA5A5_A5A5;
        req_valid3   = 1'b1;
        acc = cycleCount;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        n = 0;
        strobes = 0;
        while (!resp_valid3 && n < 50) begin
            if (mem_is_write3) begin
                strobes++;
                checkOutput("r3_strobe_data", mem_in3, 32'hA5A5_A5A5);
                checkOutput("r3_strobe_sel", mem_selector3, 2'b01);
            end
            @(posedge clk); #1; n++;
        end
        checkOutput("r3_next_latency", cycleCount - acc, 6);
        checkOutput("r3_next_strobes", strobes, 1);
        checkOutput("r3_next_err", resp_err3, 0);
        checkOutput("r3_next_rdata", resp_rdata3, 0);
        @(posedge clk); #1;
        checkOutput("r3_next_idle", req_ready3, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        reset = 1'b1; reset3 = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_selector = 2'b00; req_address = '0; req_wdata = '0;
        resp_ready = 1'b1;
        req_valid3 = 1'b0; req_write3 = 1'b0; req_selector3 = 2'b00; req_address3 = '0; req_wdata3 = '0;
        resp_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_mem_is_write", mem_is_write, 0);
        checkOutput("reset_mem_address", mem_address, 0);
        checkOutput("reset_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0; reset3 = 1'b0;
        @(posedge clk); #1;

        //            w     sel    addr      wdata          rdata          err  lat strb sel    addr      din           held
        applyStimulus(1'b1, 2'b01, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0, 4, 2, 2'b01, 16'h0010, 32'hDEADBEEF, 1);
        applyStimulus(1'b0, 2'b01, 16'h0010, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 2, 0, 2'b01, 16'h0010, 32'h0,        1);
        applyStimulus(1'b0, 2'b11, 16'h1234, 32'h0,        32'hC0571234, 1'b0, 2, 0, 2'b11, 16'h1234, 32'h0,        1);
        applyStimulus(1'b1, 2'b00, 16'h0010, 32'h0BADF00D, 32'h0,        1'b1, 1, 0, 2'b00, 16'h0000, 32'h0,        1);
        applyStimulus(1'b1, 2'b11, 16'h0010, 32'h0BADF00D, 32'h0,        1'b1, 1, 0, 2'b00, 16'h0000, 32'h0,        1);
        applyStimulus(1'b0, 2'b10, 16'h0020, 32'h0,        32'h0,        1'b1, 1, 0, 2'b00, 16'h0000, 32'h0,        1);
        applyStimulus(1'b0, 2'b01, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 2'b01, 16'h0010, 32'h0,        1);
        applyStimulus(1'b0, 2'b00, 16'h0005, 32'h0,        32'hA0A00005, 1'b0, 2, 0, 2'b00, 16'h0005, 32'h0,        6);
        applyStimulus(1'b1, 2'b01, 16'h0011, 32'hCAFEF00D, 32'h0,        1'b0, 4, 2, 2'b01, 16'h0011, 32'hCAFEF00D, 3);
        applyStimulus(1'b0, 2'b01, 16'h0011, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 2'b01, 16'h0011, 32'h0,        1);

        resetDuringStrobe();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
